// File: rtl/rotator_share_ctrl.sv
// Round-robin sequencer sharing one external multi-cycle rotate-right shifter among NREQ clients.
// Optional macro ROT_LEFT_EN adds req_dir so clients can request left rotations.
module rotator_share_ctrl #(
    parameter int NREQ   = 2,
    parameter int WIDTH  = 16,
    parameter int SHW    = 4,
    parameter int SETTLE = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    input  logic [NREQ*SHW-1:0]    req_amt,
`ifdef ROT_LEFT_EN
    input  logic [NREQ-1:0]        req_dir,
`endif
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [WIDTH-1:0]       result,
    output logic                   busy,
    output logic [WIDTH-1:0]       rot_in,
    output logic [SHW-1:0]         rot_sel,
    input  logic [WIDTH-1:0]       rot_out
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

    state_t         state;
    logic [OW-1:0]  ptr;
    logic [OW-1:0]  owner;
    logic [CW-1:0]  cnt;

    logic           found_hi;
    logic           found_any;
    logic [OW-1:0]  win_hi;
    logic [OW-1:0]  win_lo;
    logic [OW-1:0]  win;
    logic [OW-1:0]  win_next;
    logic [WIDTH-1:0] win_data;
    logic [SHW-1:0] win_amt;
    logic [SHW-1:0] win_sel;

    // Lowest set request at or above ptr wins; otherwise wrap to the lowest set request overall.
    always_comb begin
        found_hi  = 1'b0;
        found_any = 1'b0;
        win_hi    = '0;
        win_lo    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found_any = 1'b1;
                win_lo    = OW'(i);
                if (OW'(i) >= ptr) begin
                    found_hi = 1'b1;
                    win_hi   = OW'(i);
                end
            end
        end
        win      = found_hi ? win_hi : win_lo;
        win_next = (win == OW'(NREQ - 1)) ? '0 : win + OW'(1);
        win_data = req_data[int'(win)*WIDTH +: WIDTH];
        win_amt  = req_amt[int'(win)*SHW +: SHW];
`ifdef ROT_LEFT_EN
        // Left by n equals right by (WIDTH-n) mod WIDTH; SHW-bit wraparound gives the mod for free.
        win_sel  = req_dir[win] ? (SHW'(0) - win_amt) : win_amt;
`else
        win_sel  = win_amt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            gnt     <= '0;
            done    <= '0;
            result  <= '0;
            busy    <= 1'b0;
            rot_in  <= '0;
            rot_sel <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    gnt <= '0;
                    if (found_any) begin
                        gnt     <= NREQ'(1) << win;
                        rot_in  <= win_data;
                        rot_sel <= win_sel;
                        owner   <= win;
                        cnt     <= CNT_LOAD;
                        busy    <= 1'b1;
                        ptr     <= win_next;
                        state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    gnt <= '0;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        result <= rot_out;
                        done   <= NREQ'(1) << owner;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotator_share_ctrl.sv
// Bench for rotator_share_ctrl: delayed shifter model, directed steps and random transactions vs a reference model.
// Build with ROT_LEFT_EN defined to exercise left rotations.
`timescale 1ns/1ps
module tb_rotator_share_ctrl;

    localparam int NREQ   = 2;
    localparam int WIDTH  = 16;
    localparam int SHW    = 4;
    localparam int SETTLE = 8;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] req_data;
    logic [7:0]  req_amt;
    logic [1:0]  req_dir;
    wire  [1:0]  gnt;
    wire  [1:0]  done;
    wire  [15:0] result;
    wire         busy;
    wire  [15:0] rot_in;
    wire  [3:0]  rot_sel;
    wire  [15:0] rot_out;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int mptr        = 0;

    rotator_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .SHW(SHW), .SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .req_amt  (req_amt),
`ifdef ROT_LEFT_EN
        .req_dir  (req_dir),
`endif
        .gnt      (gnt),
        .done     (done),
        .result   (result),
        .busy     (busy),
        .rot_in   (rot_in),
        .rot_sel  (rot_sel),
        .rot_out  (rot_out)
    );

    function automatic logic [15:0] rotr(input logic [15:0] x, input int a);
        logic [31:0] t;
        t = {x, x} >> (a % 16);
        return t[15:0];
    endfunction

    function automatic logic [15:0] rotl(input logic [15:0] x, input int a);
        logic [31:0] xx;
        logic [31:0] t;
        xx = {16'h0, x};
        t  = (xx << (a % 16)) | (xx >> (16 - (a % 16)));
        return t[15:0];
    endfunction

    // Slow external shifter
    assign #76 rot_out = rotr(rot_in, int'(rot_sel));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: drive the request, wait for the grant, follow it to done and busy release.
    task automatic do_txn(input string tag, input logic [1:0] mask, input logic [31:0] d,
                          input logic [7:0] a, input logic [1:0] dir, output int w, output int t0);
        int          amt;
        logic        left;
        logic [15:0] data;
        logic [3:0]  sel;
        logic [15:0] exp_res;
        bit          got;
        req      = mask;
        req_data = d;
        req_amt  = a;
        req_dir  = dir;
        w = -1;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (mptr + i) % NREQ;
            if (w < 0 && mask[idx]) w = idx;
        end
        amt  = int'(a[w*4 +: 4]);
        data = d[w*16 +: 16];
        left = 1'b0;
`ifdef ROT_LEFT_EN
        left = dir[w];
`endif
        sel     = left ? 4'((16 - amt) % 16) : 4'(amt);
        exp_res = left ? rotl(data, amt) : rotr(data, amt);
        got = 0;
        t0  = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (gnt != 2'b00) got = 1;
        end
        check({tag, "_gnt"}, {30'h0, gnt}, 32'(1) << w);
        if (!got) return;
        t0 = cyc;
        check({tag, "_grant_state"}, {done, busy, rot_in, rot_sel}, {2'b00, 1'b1, data, sel});
        mptr = (w + 1) % NREQ;
        for (int k = 1; k < SETTLE; k++) begin
            tick();
            check({tag, "_settle"}, {gnt, done, busy, rot_in, rot_sel}, {2'b00, 2'b00, 1'b1, data, sel});
        end
        tick();
        check({tag, "_done"}, {gnt, done, busy, result}, {2'b00, 2'(32'(1) << w), 1'b1, exp_res});
        tick();
        check({tag, "_release"}, {gnt, done, busy, result}, {2'b00, 2'b00, 1'b0, exp_res});
    endtask

    initial begin
        int w, t0, prev_t0;
        bit got;
        req      = 2'b00;
        req_data = 32'h0;
        req_amt  = 8'h0;
        req_dir  = 2'b00;

        // 1. asynchronous reset, idle with no requests
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", {12'h0, gnt, done, busy, rot_sel}, 32'h0);
        check("reset_data", {rot_in, result}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("idle_quiet", {gnt, done, busy, rot_in, rot_sel}, 32'h0);
        end

        // 2. single request from requester 0
        do_txn("t2", 2'b01, {16'h0, 16'h8001}, {4'd0, 4'd1}, 2'b00, w, t0);
        check("t2_result", {16'h0, result}, 32'h0000C000);
        check("t2_sel", {28'h0, rot_sel}, 32'd1);
        req = 2'b00;

        // 4. requester 1: amount 0 pass-through, amount 15
        do_txn("t4a", 2'b10, {16'hA5A5, 16'h0}, {4'd0, 4'd3}, 2'b00, w, t0);
        check("t4a_result", {16'h0, result}, 32'h0000A5A5);
        do_txn("t4b", 2'b10, {16'h0001, 16'h0}, {4'd15, 4'd3}, 2'b00, w, t0);
        check("t4b_result", {16'h0, result}, 32'h00000002);
        req = 2'b00;
        tick();

        // 3. both requesting continuously: 0,1,0,1 at SETTLE+2 spacing
        prev_t0 = -1;
        for (int n = 0; n < 4; n++) begin
            do_txn("t3", 2'b11, {16'h1234 + 16'(n), 16'h8421 + 16'(n)}, {4'(n + 2), 4'(n + 5)},
                   2'b00, w, t0);
            check("t3_order", 32'(w), 32'(n % 2));
            if (n > 0) check("t3_spacing", 32'(t0 - prev_t0), 32'(SETTLE + 2));
            prev_t0 = t0;
        end

        // 5. reset during SETTLE aborts, pointer returns to 0
        req = 2'b00;
        tick();
        req = 2'b01;
        req_data = {16'h0F0F, 16'hF00F};
        req_amt  = 8'h33;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (gnt != 2'b00) got = 1;
        end
        check("t5_gnt", {30'h0, gnt}, 32'h1);
        mptr = 1;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        #1;
        check("t5_abort", {12'h0, gnt, done, busy, rot_sel}, 32'h0);
        check("t5_abort_data", {rot_in, result}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t5_no_done", {28'h0, done, busy, 1'b0}, 32'h0);
        end
        rst_n = 1'b1;
        mptr  = 0;
        do_txn("t5_next", 2'b11, {16'hC3C3, 16'h5A5A}, {4'd7, 4'd9}, 2'b00, w, t0);
        check("t5_winner", 32'(w), 32'd0);

        // random transactions
        for (int n = 0; n < 24; n++) begin
            do_txn("rand", 2'($urandom_range(1, 3)), $urandom, 8'($urandom), 2'($urandom), w, t0);
            if ($urandom_range(0, 3) == 0) begin
                req = 2'b00;
                tick();
                check("rand_idle", {28'h0, gnt, busy, 1'b0}, 32'h0);
            end
        end

`ifdef ROT_LEFT_EN
        // 6. left rotations
        req = 2'b00;
        tick();
        do_txn("t6a", 2'b01, {16'h0, 16'h1234}, {4'd0, 4'd4}, 2'b01, w, t0);
        check("t6a_sel", {28'h0, rot_sel}, 32'd12);
        check("t6a_result", {16'h0, result}, 32'h00002341);
        do_txn("t6b", 2'b10, {16'h1234, 16'h0}, {4'd0, 4'd4}, 2'b10, w, t0);
        check("t6b_sel", {28'h0, rot_sel}, 32'd0);
        check("t6b_result", {16'h0, result}, 32'h00001234);
`endif

        req = 2'b00;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
